ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
Consumes the byte stream from the PS/2 receiver (keycode + one-cycle key_valid strobe) and decodes scan code set 2 prefixes (E0, F0, E1) into complete key events. Tracks shift state and translates printable keys to ASCII. Buffers events in a small FIFO with a valid/ready handshake toward the game/UI logic.

Parameters:
FIFO_DEPTH, 8, event FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  system clock, same domain as the PS/2 receiver
rst_n  input  1  asynchronous active-low reset
keycode  input  8  byte from PS/2 receiver, qualified by key_valid
key_valid  input  1  one-cycle strobe, byte present
ev_valid  output  1  FIFO non-empty; head event on ev_* outputs
ev_ready  input  1  consumer accepts head event when ev_valid & ev_ready
ev_code  output  8  base scan code, prefixes stripped
ev_ext  output  1  event carried an E0 prefix
ev_break  output  1  1 = key release, 0 = key press
ev_ascii  output  8  ASCII of the key, 0x00 if non-printable or extended
shift_held  output  1  left (0x12) or right (0x59) shift currently pressed
overflow  output  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- One clock, asynchronous active-low reset. Reset: ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_ascii=0, shift_held=0, overflow=0, FIFO empty, FSM in S_IDLE, discard counter 0.
- Bytes are processed only on cycles with key_valid=1; all other cycles leave the FSM unchanged.
- FSM states: S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP.
  - S_IDLE: E0 -> S_E0; F0 -> S_F0; E1 -> S_SKIP with the discard counter loaded to 7; filtered byte -> stay; any other byte -> emit make {ext=0}.
  - S_E0: F0 -> S_E0F0; E0 -> stay; other byte -> emit make {ext=1} -> S_IDLE.
  - S_F0: E0/F0 -> stay; other byte -> emit break {ext=0} -> S_IDLE.
  - S_E0F0: E0/F0 -> stay; other byte -> emit break {ext=1} -> S_IDLE.
  - S_SKIP: each byte decrements the counter; return to S_IDLE on the byte that makes it 0. The Pause sequence (E1 14 77 E1 F0 14 F0 77) emits nothing.
- Filtered bytes: 00, AA, EE, FA, FC, FD, FE, FF. In S_IDLE these are ignored with no event. In prefix states they are emitted as ordinary codes.
- Shift tracking: a non-extended make of 0x12 or 0x59 sets the corresponding flag; its break clears it. shift_held = L|R, updated in the same cycle the event is emitted.
- ASCII is computed at emit time using the shift state before the update. ext=1 gives 0x00 for every code.
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Lowercase, uppercase when shift_held.
  - Digits (shift-independent): 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9.
  - Others: 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08, 76 -> 0x1B. Everything else -> 0x00.
  - Breaks carry the same ASCII as the matching make.
- Emit = push into the FIFO one cycle after the key_valid cycle. ev_valid rises the cycle after the push (show-ahead head). Latency from key_valid to ev_valid is 2 cycles when the FIFO is empty.
- Pop when ev_valid & ev_ready. Pop with FIFO empty has no effect.
- Push and pop in the same cycle are both honoured, including when full (count unchanged).
- Push while full without a simultaneous pop drops the event and sets overflow. overflow clears only on reset.
- Reset mid-sequence (e.g. after E0 F0) returns to S_IDLE; the next byte is decoded with no prefix.

Optional Feature:
PS2_KEYDEC_TYPEMATIC_FILTER_EN
- Defined: a register holds {ext, code} of the last emitted make plus a valid bit. A make equal to it while valid is dropped (auto-repeat suppression). Any break of the same key clears valid; any different make replaces the register.
- Not defined: every make is pushed, including typematic repeats.

Test Plan:
- Bytes 1C, F0 1C -> events {1C, ext0, brk0, 0x61} then {1C, ext0, brk1, 0x61}; ev_valid 2 cycles after the first key_valid.
- 12, 1C, F0 1C, F0 12 -> shift_held=1 after the first event; A events carry ascii 0x41; shift_held=0 after the final break.
- E0 75, E0 F0 75 -> {75, ext1, brk0, 0x00}, {75, ext1, brk1, 0x00}; bytes AA and FA alone -> no events.
- Pause sequence E1 14 77 E1 F0 14 F0 77 followed by 29 -> exactly one event {29, ext0, brk0, 0x20}.
- ev_ready=0, push FIFO_DEPTH+1 makes -> 8 events retained in order, overflow=1. Simultaneous pop and push when full -> no drop.
- With the macro: 1C, 1C, 1C, F0 1C, 1C -> three events (make, break, make). Without the macro -> five events.

Source files
------------

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_decoder: PS/2 set-2 byte stream -> key events (ASCII, shift)      |
// | in an event FIFO. Optional: PS2_KEYDEC_TYPEMATIC_FILTER_EN. Rev 1.0       |
// +--------------------------------------------------------------------------+
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] keycode,
  input  logic       key_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic       shift_held,
  output logic       overflow
);

  localparam int              C_AW       = $clog2(FIFO_DEPTH);
  localparam logic [C_AW:0]   C_DEPTH    = FIFO_DEPTH[C_AW:0];
  localparam logic [C_AW:0]   C_CNT_ONE  = 1;
  localparam logic [C_AW-1:0] C_PTR_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_E0   = 3'd1,
    S_F0   = 3'd2,
    S_E0F0 = 3'd3,
    S_SKIP = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_skip_cnt;
  logic       r_emit;
  logic [7:0] r_em_code;
  logic       r_em_ext;
  logic       r_em_brk;
  logic       r_shift_l;
  logic       r_shift_r;
  logic       r_overflow;

  function automatic logic is_filtered(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                          input logic shift);
    logic [7:0] letter;
    letter = 8'h00;
    if (ext) return 8'h00;
    case (code)
      8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
      8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
      8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
      8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
      8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
      8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
      8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
      8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
      8'h35: letter = "y";  8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
    if (letter != 8'h00) return shift ? (letter - 8'h20) : letter;
    case (code)
      8'h45: return "0";  8'h16: return "1";  8'h1E: return "2";
      8'h26: return "3";  8'h25: return "4";  8'h2E: return "5";
      8'h36: return "6";  8'h3D: return "7";  8'h3E: return "8";
      8'h46: return "9";
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  // Prefix decoder; a completed key is staged in r_em_* and pushed next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_skip_cnt <= 3'd0;
      r_emit     <= 1'b0;
      r_em_code  <= 8'h00;
      r_em_ext   <= 1'b0;
      r_em_brk   <= 1'b0;
    end else begin
      r_emit <= 1'b0;
      if (key_valid) begin
        case (r_state)
          S_IDLE: begin
            if (keycode == 8'hE0) begin
              r_state <= S_E0;
            end else if (keycode == 8'hF0) begin
              r_state <= S_F0;
            end else if (keycode == 8'hE1) begin
              r_state    <= S_SKIP;
              r_skip_cnt <= 3'd7;
            end else if (!is_filtered(keycode)) begin
              r_emit    <= 1'b1;
              r_em_code <= keycode;
              r_em_ext  <= 1'b0;
              r_em_brk  <= 1'b0;
            end
          end
          S_E0: begin
            if (keycode == 8'hF0) begin
              r_state <= S_E0F0;
            end else if (keycode != 8'hE0) begin
              r_emit    <= 1'b1;
              r_em_code <= keycode;
              r_em_ext  <= 1'b1;
              r_em_brk  <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
          S_F0, S_E0F0: begin
            if (keycode != 8'hE0 && keycode != 8'hF0) begin
              r_emit    <= 1'b1;
              r_em_code <= keycode;
              r_em_ext  <= (r_state == S_E0F0);
              r_em_brk  <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
          S_SKIP: begin
            r_skip_cnt <= r_skip_cnt - 3'd1;
            if (r_skip_cnt == 3'd1) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  logic w_repeat;
`ifdef PS2_KEYDEC_TYPEMATIC_FILTER_EN
  logic       r_tm_valid;
  logic [8:0] r_tm_key;
  assign w_repeat = r_emit & ~r_em_brk & r_tm_valid & (r_tm_key == {r_em_ext, r_em_code});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tm_valid <= 1'b0;
      r_tm_key   <= 9'h000;
    end else if (r_emit) begin
      if (!r_em_brk) begin
        r_tm_valid <= 1'b1;
        r_tm_key   <= {r_em_ext, r_em_code};
      end else if (r_tm_key == {r_em_ext, r_em_code}) begin
        r_tm_valid <= 1'b0;
      end
    end
  end
`else
  assign w_repeat = 1'b0;
`endif

  // ASCII uses the shift state as it stood before this event updates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
    end else if (r_emit && !r_em_ext) begin
      if (r_em_code == 8'h12) r_shift_l <= ~r_em_brk;
      if (r_em_code == 8'h59) r_shift_r <= ~r_em_brk;
    end
  end
  assign shift_held = r_shift_l | r_shift_r;

  logic [17:0]     r_mem [FIFO_DEPTH];
  logic [C_AW-1:0] r_wr_ptr;
  logic [C_AW-1:0] r_rd_ptr;
  logic [C_AW:0]   r_count;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr;
  logic [17:0]     w_wdata;
  logic [17:0]     w_head;

  assign w_push  = r_emit & ~w_repeat;
  assign w_pop   = ev_valid & ev_ready;
  assign w_full  = (r_count == C_DEPTH);
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_wdata = {ascii_of(r_em_code, r_em_ext, shift_held), r_em_brk, r_em_ext, r_em_code};

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      if (w_wr && !w_pop)      r_count <= r_count + C_CNT_ONE;
      else if (!w_wr && w_pop) r_count <= r_count - C_CNT_ONE;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
  assign ev_valid = (r_count != '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign ev_code  = ev_valid ? w_head[7:0]   : 8'h00;
  assign ev_ext   = ev_valid ? w_head[8]     : 1'b0;
  assign ev_break = ev_valid ? w_head[9]     : 1'b0;
  assign ev_ascii = ev_valid ? w_head[17:10] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_key_decoder: directed + random bench with a queue-based model.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_ps2_key_decoder;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       key_valid = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_ext, ev_break, shift_held, overflow;
  logic [7:0] ev_code, ev_ascii;

  int checks = 0;
  int errors = 0;
  int m_pops = 0;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .keycode(keycode), .key_valid(key_valid),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_ascii(ev_ascii), .shift_held(shift_held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                               8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                               8'h35, 8'h1A};
  logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                              8'h3E, 8'h46};

  function automatic logic [7:0] m_ascii(input logic [7:0] c, input bit ext, input bit sh);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'(sh ? 65 + i : 97 + i);
    for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'(48 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    if (c == 8'h76) return 8'h1B;
    return 8'h00;
  endfunction

  // Model state: pending prefixes, staged key, shift keys, event queue.
  bit          m_ext, m_brk, m_pend, m_pext, m_pbrk, m_sl, m_sr, m_ovf, m_tv;
  int          m_skip;
  logic [7:0]  m_pcode;
  logic [8:0]  m_tk;
  logic [17:0] m_q [$];

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pend = 0; m_pext = 0; m_pbrk = 0; m_sl = 0; m_sr = 0;
    m_ovf = 0; m_tv = 0; m_skip = 0; m_pcode = 8'h00; m_tk = 9'h000;
    m_q.delete();
  endtask

  initial model_reset();

  always begin : compare
    logic       s_kv, s_rdy, s_rst, pop, was_full, drop;
    logic [7:0] s_kc, asc;
    logic [20:0] act, exp;
    @(posedge clk);
    s_kv = key_valid; s_kc = keycode; s_rdy = ev_ready; s_rst = rst_n;
    if (!s_rst) begin
      model_reset();
    end else begin
      was_full = (m_q.size() == DEPTH);
      pop = (m_q.size() > 0) && s_rdy;
      if (pop) begin
        void'(m_q.pop_front());
        m_pops++;
      end
      if (m_pend) begin
        asc  = m_ascii(m_pcode, m_pext, m_sl | m_sr);
        drop = 1'b0;
`ifdef PS2_KEYDEC_TYPEMATIC_FILTER_EN
        if (!m_pbrk) begin
          drop = m_tv && (m_tk == {m_pext, m_pcode});
          m_tv = 1; m_tk = {m_pext, m_pcode};
        end else if (m_tk == {m_pext, m_pcode}) begin
          m_tv = 0;
        end
`endif
        if (!drop) begin
          if (!was_full || pop) m_q.push_back({asc, m_pbrk, m_pext, m_pcode});
          else m_ovf = 1;
        end
        if (!m_pext && m_pcode == 8'h12) m_sl = !m_pbrk;
        if (!m_pext && m_pcode == 8'h59) m_sr = !m_pbrk;
      end
      m_pend = 0;
      if (s_kv) begin
        if (m_skip > 0) m_skip--;
        else if (!m_ext && !m_brk && s_kc == 8'hE1) m_skip = 7;
        else if (s_kc == 8'hE0) begin
          if (!m_brk) m_ext = 1;
        end else if (s_kc == 8'hF0) m_brk = 1;
        else if (!m_ext && !m_brk &&
                 (s_kc inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF})) begin
        end else begin
          m_pend = 1; m_pcode = s_kc; m_pext = m_ext; m_pbrk = m_brk;
          m_ext = 0; m_brk = 0;
        end
      end
    end
    #1;
    act = {ev_valid, ev_valid ? {ev_code, ev_ext, ev_break, ev_ascii} : 18'h0, shift_held, overflow};
    exp = {m_q.size() > 0,
           (m_q.size() > 0) ? {m_q[0][7:0], m_q[0][8], m_q[0][9], m_q[0][17:10]} : 18'h0,
           m_sl | m_sr, m_ovf};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, act, exp);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); key_valid = 1'b1; keycode = b;
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic pop_check(input string nm, input logic [7:0] c, input logic e,
                           input logic b, input logic [7:0] a);
    chk(nm, {ev_valid, ev_code, ev_ext, ev_break, ev_ascii}, {1'b1, c, e, b, a});
    ev_ready = 1'b1;
    @(negedge clk); ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  logic [7:0] pool [24] = '{8'h1C, 8'h32, 8'h21, 8'h15, 8'h45, 8'h16, 8'h12, 8'h59,
                            8'h12, 8'h59, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hE1,
                            8'h29, 8'h5A, 8'h66, 8'h76, 8'hAA, 8'hFA, 8'h00, 8'h75};

  initial begin : stim
    int snap;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outputs", {ev_valid, ev_code, ev_ext, ev_break, ev_ascii, shift_held, overflow}, 32'h0);

    send(8'h1C);
    chk("latency_not_yet", ev_valid, 1'b0);
    @(negedge clk);
    chk("latency_2cyc", ev_valid, 1'b1);
    send(8'hF0); send(8'h1C); repeat (2) @(negedge clk);
    pop_check("a_make", 8'h1C, 0, 0, 8'h61);
    pop_check("a_break", 8'h1C, 0, 1, 8'h61);

    send(8'h12); @(negedge clk);
    chk("shift_set", shift_held, 1'b1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); repeat (2) @(negedge clk);
    pop_check("lshift_make", 8'h12, 0, 0, 8'h00);
    pop_check("A_make", 8'h1C, 0, 0, 8'h41);
    pop_check("A_break", 8'h1C, 0, 1, 8'h41);
    pop_check("lshift_break", 8'h12, 0, 1, 8'h00);
    chk("shift_clear", shift_held, 1'b0);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA); send(8'hFA); repeat (2) @(negedge clk);
    pop_check("ext_make", 8'h75, 1, 0, 8'h00);
    pop_check("ext_break", 8'h75, 1, 1, 8'h00);
    chk("filtered_none", ev_valid, 1'b0);

    foreach (pool[i]) if (i < 0) send(8'h00);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); send(8'h29);
    repeat (2) @(negedge clk);
    pop_check("after_pause", 8'h29, 0, 0, 8'h20);
    chk("pause_only_one", ev_valid, 1'b0);

    snap = m_pops;
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    send(8'h2C); send(8'h35); send(8'h3C); send(8'h43);
    repeat (2) @(negedge clk);
    chk("full_head", ev_code, 8'h15);
    chk("full_no_ovf", overflow, 1'b0);
    send(8'h44);
    ev_ready = 1'b1;
    @(negedge clk); ev_ready = 1'b0;
    @(negedge clk);
    chk("pushpop_full_no_ovf", overflow, 1'b0);
    chk("pushpop_head", ev_code, 8'h1D);
    send(8'h4D); repeat (2) @(negedge clk);
    chk("ovf_sticky", overflow, 1'b1);
    ev_ready = 1'b1; repeat (12) @(negedge clk); ev_ready = 1'b0;
    chk("drained", ev_valid, 1'b0);
    chk("drain_count", m_pops - snap, 9);
    chk("ovf_held", overflow, 1'b1);

    do_reset();
    chk("ovf_reset", overflow, 1'b0);
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h1C); repeat (2) @(negedge clk);
    pop_check("mid_seq_reset", 8'h1C, 0, 0, 8'h61);

    do_reset();
    ev_ready = 1'b1;
    snap = m_pops;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    repeat (4) @(negedge clk);
`ifdef PS2_KEYDEC_TYPEMATIC_FILTER_EN
    chk("typematic_count", m_pops - snap, 3);
`else
    chk("typematic_count", m_pops - snap, 5);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n     = (i != 1500);
      key_valid = 1'($urandom_range(0, 1));
      keycode   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 23)];
      ev_ready  = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    key_valid = 1'b0; ev_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("final_drain", ev_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
